// File: rtl/tc_pkg.sv
// tc_pkg: shared types, default tile geometry and helpers for the tensor-core reduction controller.
package tc_pkg;
  localparam int TC_TILE_M  = 4;
  localparam int TC_TILE_K  = 8;
  localparam int TC_TILE_N  = 4;
  localparam int TC_DW_DATA = 8;
  localparam int DW_LINE    = TC_TILE_N * TC_DW_DATA;
  localparam int NUM_IN     = TC_TILE_M * TC_TILE_K * TC_TILE_N;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} tc_rn_ctrl_state_t;
  // Sign-extends the low w bits of v to 64 bits; callers truncate to their lane width.
  function automatic logic [63:0] sext(input logic [63:0] v, input int w);
    logic [63:0] r;
    for (int b = 0; b < 64; b++) r[b] = (b < w) ? v[b] : v[w-1];
    return r;
  endfunction
endpackage

// File: rtl/tc_valid_pipe.sv
// tc_valid_pipe: fixed-latency token shift register for units without back-pressure.
module tc_valid_pipe #(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_i,
  output logic tail_o,
  output logic any_o,
  output logic pend_o
);
  logic [DEPTH-1:0] q_q, q_d;
  // pend_o flags tokens still behind the tail stage.
  always_comb begin
    q_d[0] = in_i;
    pend_o = 1'b0;
    for (int i = 1; i < DEPTH; i++) begin
      q_d[i] = q_q[i-1];
      pend_o = pend_o | q_q[i-1];
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  assign tail_o = q_q[DEPTH-1];
  assign any_o  = |q_q;
endmodule

// File: rtl/tc_rn_ctrl.sv
// tc_rn_ctrl: sequences K-slices through the reduction network and accumulates the reduced tile.
module tc_rn_ctrl
  import tc_pkg::*;
#(
  parameter int TILE_M  = 4,
  parameter int TILE_K  = 8,
  parameter int TILE_N  = 4,
  parameter int DW_DATA = 8,
  parameter int DW_ACC  = 24,
  parameter int RN_LAT  = 3,
  parameter int KW      = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   cfg_start,
  input  logic [KW-1:0]                          cfg_k_steps,
  output logic                                   busy,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [TILE_M*TILE_K*TILE_N*DW_DATA-1:0] in_data,
  output logic [TILE_M*TILE_K*TILE_N*DW_DATA-1:0] rn_in,
  input  logic [TILE_M*TILE_N*DW_DATA-1:0]        rn_out,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [TILE_M*TILE_N*DW_ACC-1:0]         out_data,
  output logic                                   done
);
  localparam int LANES = TILE_M * TILE_N;
  tc_rn_ctrl_state_t state_q, state_d;
  logic [KW-1:0] k_tgt_q, k_tgt_d, cnt_q, cnt_d, cnt_inc;
  logic [LANES*DW_ACC-1:0] acc_q, acc_d;
  logic done_q, done_d, accept, tail, any, pend;
  tc_valid_pipe #(.DEPTH(RN_LAT)) u_pipe (
    .clk    (clk),
    .rst_n  (rst),
    .in_i   (accept),
    .tail_o (tail),
    .any_o  (any),
    .pend_o (pend)
  );
  assign busy      = state_q != IDLE;
  assign in_ready  = state_q == RUN;
  assign out_valid = state_q == OUT;
  assign out_data  = acc_q;
  assign done      = done_q;
  assign rn_in     = in_data;
  always_comb begin
    accept  = in_valid & in_ready;
    cnt_inc = cnt_q + KW'(1);
    state_d = state_q;
    k_tgt_d = k_tgt_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    done_d  = (state_q == OUT) & out_ready;
    if (tail)
      for (int i = 0; i < LANES; i++)
        acc_d[i*DW_ACC +: DW_ACC] = acc_q[i*DW_ACC +: DW_ACC]
                                  + DW_ACC'(sext(64'(rn_out[i*DW_DATA +: DW_DATA]), DW_DATA));
    if (state_q == IDLE && cfg_start) begin
      state_d = RUN;
      k_tgt_d = (cfg_k_steps == '0) ? KW'(1) : cfg_k_steps;
      cnt_d   = '0;
      acc_d   = '0;
    end
    if (state_q == RUN && accept) begin
      cnt_d   = cnt_inc;
      state_d = (cnt_inc == k_tgt_q) ? DRAIN : state_q;
    end
    // The last token lands in the accumulator on the same edge we enter OUT.
    if (state_q == DRAIN && (!any || (tail && !pend))) state_d = OUT;
    if (state_q == OUT && out_ready) state_d = IDLE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      k_tgt_q <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_tgt_q <= k_tgt_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      done_q  <= done_d;
    end
endmodule

// File: tb/tb_tc_rn_ctrl.sv
// tb_tc_rn_ctrl: directed scoreboard bench for tc_rn_ctrl with a delay-line reduction-network model.
module tb_tc_rn_ctrl;
  localparam int M = 4, K = 8, N = 4, DD = 8, DA = 8, LAT = 3, KW = 8;
  localparam int L = M * N;
  logic clk = 1'b0, rst, cfg_start, busy, in_valid, in_ready, out_valid, out_ready, done;
  logic [KW-1:0] cfg_k_steps;
  logic [M*K*N*DD-1:0] in_data, rn_in;
  logic [L*DD-1:0] rn_out;
  logic [L*DA-1:0] out_data;
  logic [7:0] cur_v;
  logic [7:0] rn_pipe [LAT];
  logic [127:0] sb [$];
  int errs = 0, checks = 0;
  int cyc = 0, last_acc = 0, rise = 0, rdy_cnt = 0, done_cnt = 0;
  logic ov_prev = 1'b0;
  tc_rn_ctrl #(.TILE_M(M), .TILE_K(K), .TILE_N(N), .DW_DATA(DD), .DW_ACC(DA), .RN_LAT(LAT), .KW(KW)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_k_steps(cfg_k_steps), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .rn_in(rn_in), .rn_out(rn_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .done(done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    rn_pipe[0] <= cur_v;
    for (int i = 1; i < LAT; i++) rn_pipe[i] <= rn_pipe[i-1];
  end
  assign in_data = {(M*K*N){cur_v}};
  assign rn_out  = {L{rn_pipe[LAT-1]}};
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (in_valid && in_ready) last_acc <= cyc;
    if (out_valid && !ov_prev) rise <= cyc;
    ov_prev <= out_valid;
    if (in_ready) rdy_cnt <= rdy_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic start_job(input logic [KW-1:0] k);
    @(posedge clk); #1 cfg_start = 1'b1; cfg_k_steps = k;
    @(posedge clk); #1 cfg_start = 1'b0;
  endtask
  task automatic slice(input logic [7:0] v);
    logic ok = 1'b0;
    in_valid = 1'b1;
    cur_v = v;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); #1;
    end
    chk("in_ready_timeout", ok, 1);
    in_valid = 1'b0;
    cur_v = 8'h55;
  endtask
  task automatic gap();
    in_valid = 1'b0;
    cur_v = 8'h55;
    @(posedge clk); #1;
  endtask
  task automatic finish_job(input int hold, input bit do_lat);
    logic [127:0] exp;
    logic seen = 1'b0;
    chk("scoreboard_nonempty", sb.size() > 0, 1);
    exp = (sb.size() > 0) ? sb.pop_front() : '0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk); seen = out_valid;
    end
    chk("out_valid_timeout", seen, 1);
    #1;
    if (do_lat) chk("latency", rise - last_acc, LAT + 1);
    chk("out_data", out_data, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_data", out_data, exp);
      chk("hold_valid", out_valid, 1);
      chk("hold_no_done", done, 0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    chk("done_pulse", done, 1);
    chk("busy_drop", busy, 0);
    chk("out_valid_drop", out_valid, 0);
    @(negedge clk);
    chk("done_single", done, 0);
  endtask
  initial begin
    int base;
    rst = 1'b0; cfg_start = 1'b0; cfg_k_steps = '0; in_valid = 1'b0; out_ready = 1'b0; cur_v = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_done", done, 0);
    @(posedge clk); #1 rst = 1'b1;
    // single slice
    start_job(8'd1);
    sb.push_back({L{8'd5}});
    slice(8'd5);
    finish_job(0, 1);
    // back-to-back slices
    base = rdy_cnt;
    start_job(8'd4);
    sb.push_back({L{8'd2}});
    slice(8'd1); slice(8'd2); slice(8'd3); slice(8'hFC);
    finish_job(0, 1);
    #1 chk("in_ready_cycles", rdy_cnt - base, 4);
    // gaps and output back-pressure
    start_job(8'd3);
    sb.push_back({L{8'h19}});
    gap(); slice(8'd10); gap(); slice(8'd20); gap(); gap(); slice(8'hFB);
    finish_job(5, 1);
    // wrap and sign extension
    start_job(8'd2);
    sb.push_back({L{8'hFE}});
    slice(8'd127); slice(8'd127);
    finish_job(0, 0);
    start_job(8'd2);
    sb.push_back({L{8'h7F}});
    slice(8'h80); slice(8'hFF);
    finish_job(0, 0);
    // zero k_steps and a stray start during RUN
    base = done_cnt;
    start_job(8'd0);
    @(posedge clk); #1 cfg_start = 1'b1; cfg_k_steps = 8'd3;
    @(posedge clk); #1 cfg_start = 1'b0;
    sb.push_back({L{8'd9}});
    slice(8'd9);
    finish_job(0, 1);
    repeat (8) @(negedge clk);
    #1;
    chk("one_done", done_cnt - base, 1);
    chk("idle_after_k0", busy, 0);
    // reset during DRAIN
    base = done_cnt;
    start_job(8'd2);
    slice(8'd50); slice(8'd50);
    chk("drain_busy", busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_in_ready", in_ready, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_done", done, 0);
    @(posedge clk); #1 rst = 1'b1;
    repeat (6) @(negedge clk);
    #1 chk("no_done_after_abort", done_cnt - base, 0);
    start_job(8'd1);
    sb.push_back({L{8'd7}});
    slice(8'd7);
    finish_job(0, 1);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
